tl_ddr_arbiter: RTL and testbench

Shares the single TileLink port of the DDR memory controller (128-bit data, 27-bit address, 8-bit source) between several host ports, such as the core's cache and a DMA engine. A-channel requests are merged with round-robin arbitration. Grants are locked for the whole of a multi-beat Put burst, and the host index is prepended to the source ID. D-channel responses are routed back to the host named by the upper source bits. Sits in the chip top between the host-side interconnect and the `ddr` block.

---
 rtl/tl_ddr_arbiter_pkg.sv | 16 +
 rtl/tl_ddr_arbiter_rr_arbiter.sv | 27 ++
 rtl/tl_ddr_arbiter.sv | 135 +++++++++++++
 tb/tb_tl_ddr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ddr_arbiter_pkg.sv
// tl_ddr_arb_pkg: shared TileLink opcodes, arbiter state encoding and burst-length helper
package tl_ddr_arb_pkg;
    localparam logic [2:0] PutFull    = 3'd0;
    localparam logic [2:0] PutPartial = 3'd1;
    localparam logic [2:0] Get        = 3'd4;

    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

    // Number of A-channel beats a request occupies; only Puts larger than one bus word are multi-beat
    function automatic logic [31:0] beats_of(input logic [2:0] opcode, input logic [31:0] size,
                                             input logic [31:0] mask_width);
        logic [31:0] lg;
        lg = 32'($clog2(mask_width));
        return ((opcode == PutFull || opcode == PutPartial) && size > lg) ? (32'd1 << (size - lg)) : 32'd1;
    endfunction
endpackage

// File: rtl/tl_ddr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after a pointer
//   i_req   request vector
//   i_ptr   index with highest priority
//   o_gnt   chosen index (i_ptr when nothing requests)
//   o_valid at least one request present
module rr_arbiter #(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic [IdxW-1:0] o_gnt,
    output logic            o_valid
);
    logic [IdxW-1:0] w_j;

    // Scan from the farthest offset down so the nearest requester is written last and wins
    always_comb begin
        o_gnt   = i_ptr;
        o_valid = |i_req;
        w_j     = i_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IdxW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) o_gnt = w_j;
        end
    end
endmodule

// File: rtl/tl_ddr_arbiter.sv
// tl_ddr_arbiter: shares the DDR controller TileLink port between NumHosts host ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   host_a_*              per-host A channel (requests in, ready out)
//   host_d_*              per-host D channel (responses out, ready in)
//   dev_a_*               merged A channel to the DDR controller, source = {host, host source}
//   dev_d_*               D channel from the DDR controller, routed by source MSBs
module tl_ddr_arbiter
    import tl_ddr_arb_pkg::*;
#(
    parameter int NumHosts        = 2,
    parameter int DataWidth       = 128,
    parameter int AddrWidth       = 27,
    parameter int HostSourceWidth = 7,
    parameter int SizeWidth       = 3,
    parameter int MaskWidth       = DataWidth / 8,
    parameter int IdxW            = (NumHosts > 1) ? $clog2(NumHosts) : 1,
    parameter int SinkSourceWidth = HostSourceWidth + IdxW
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NumHosts-1:0]                       host_a_valid_i,
    output logic [NumHosts-1:0]                       host_a_ready_o,
    input  logic [NumHosts-1:0][2:0]                  host_a_opcode_i,
    input  logic [NumHosts-1:0][SizeWidth-1:0]        host_a_size_i,
    input  logic [NumHosts-1:0][HostSourceWidth-1:0]  host_a_source_i,
    input  logic [NumHosts-1:0][AddrWidth-1:0]        host_a_address_i,
    input  logic [NumHosts-1:0][MaskWidth-1:0]        host_a_mask_i,
    input  logic [NumHosts-1:0][DataWidth-1:0]        host_a_data_i,
    output logic [NumHosts-1:0]                       host_d_valid_o,
    input  logic [NumHosts-1:0]                       host_d_ready_i,
    output logic [NumHosts-1:0][2:0]                  host_d_opcode_o,
    output logic [NumHosts-1:0][SizeWidth-1:0]        host_d_size_o,
    output logic [NumHosts-1:0][HostSourceWidth-1:0]  host_d_source_o,
    output logic [NumHosts-1:0]                       host_d_denied_o,
    output logic [NumHosts-1:0][DataWidth-1:0]        host_d_data_o,
    output logic                                      dev_a_valid_o,
    input  logic                                      dev_a_ready_i,
    output logic [2:0]                                dev_a_opcode_o,
    output logic [SizeWidth-1:0]                      dev_a_size_o,
    output logic [SinkSourceWidth-1:0]                dev_a_source_o,
    output logic [AddrWidth-1:0]                      dev_a_address_o,
    output logic [MaskWidth-1:0]                      dev_a_mask_o,
    output logic [DataWidth-1:0]                      dev_a_data_o,
    input  logic                                      dev_d_valid_i,
    output logic                                      dev_d_ready_o,
    input  logic [2:0]                                dev_d_opcode_i,
    input  logic [SizeWidth-1:0]                      dev_d_size_i,
    input  logic [SinkSourceWidth-1:0]                dev_d_source_i,
    input  logic                                      dev_d_denied_i,
    input  logic [DataWidth-1:0]                      dev_d_data_i
);
    localparam int CntW = 2 ** SizeWidth;

    state_t          r_state, w_state_nxt;
    logic [IdxW-1:0] r_ptr, w_ptr_nxt, r_gnt, w_gnt_nxt, w_pick, w_gnt, w_ptr_inc, w_didx;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]     w_beats;
    logic            w_any, w_fire, w_d_in;

    rr_arbiter #(.N(NumHosts), .IdxW(IdxW)) u_rr (
        .i_req  (host_a_valid_i),
        .i_ptr  (r_ptr),
        .o_gnt  (w_pick),
        .o_valid(w_any)
    );

    // A channel: live pick in IDLE, registered grant while stalled or mid-burst
    always_comb begin
        w_gnt          = (r_state == IDLE) ? w_pick : r_gnt;
        dev_a_valid_o  = !rst_i && ((r_state == IDLE) ? w_any : host_a_valid_i[w_gnt]);
        w_fire         = dev_a_valid_o && dev_a_ready_i;
        host_a_ready_o = '0;
        host_a_ready_o[w_gnt] = dev_a_ready_i && !rst_i;
        dev_a_opcode_o  = host_a_opcode_i[w_gnt];
        dev_a_size_o    = host_a_size_i[w_gnt];
        dev_a_source_o  = {w_gnt, host_a_source_i[w_gnt]};
        dev_a_address_o = host_a_address_i[w_gnt];
        dev_a_mask_o    = host_a_mask_i[w_gnt];
        dev_a_data_o    = host_a_data_i[w_gnt];
        w_beats         = beats_of(host_a_opcode_i[w_gnt], 32'(host_a_size_i[w_gnt]), 32'(MaskWidth));
        w_ptr_inc       = (int'(w_gnt) == NumHosts - 1) ? '0 : w_gnt + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        if (r_state == BURST) begin
            if (w_fire) begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CntW'(1)) w_state_nxt = IDLE;
            end
        end else if (dev_a_valid_o) begin
            w_gnt_nxt = w_gnt;
            if (w_fire) begin
                w_ptr_nxt   = w_ptr_inc;
                w_cnt_nxt   = CntW'(w_beats - 32'd1);
                w_state_nxt = (w_beats > 32'd1) ? BURST : IDLE;
            end else begin
                w_state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // D channel: steer only valid/ready; an index beyond NumHosts is sunk
    assign w_didx = dev_d_source_i[SinkSourceWidth-1 -: IdxW];
    assign w_d_in = int'(w_didx) < NumHosts;

    always_comb begin
        host_d_valid_o = '0;
        host_d_valid_o[w_didx] = dev_d_valid_i && w_d_in && !rst_i;
        dev_d_ready_o  = w_d_in ? host_d_ready_i[w_didx] : 1'b1;
    end

    assign host_d_opcode_o = {NumHosts{dev_d_opcode_i}};
    assign host_d_size_o   = {NumHosts{dev_d_size_i}};
    assign host_d_source_o = {NumHosts{dev_d_source_i[HostSourceWidth-1:0]}};
    assign host_d_denied_o = {NumHosts{dev_d_denied_i}};
    assign host_d_data_o   = {NumHosts{dev_d_data_i}};
endmodule

// File: tb/tb_tl_ddr_arbiter.sv
// tb_tl_ddr_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_tl_ddr_arbiter;
    import tl_ddr_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        a_valid, a_ready;
    logic [1:0][2:0]   a_opc, a_size;
    logic [1:0][6:0]   a_src;
    logic [1:0][26:0]  a_addr;
    logic [1:0][15:0]  a_mask;
    logic [1:0][127:0] a_data;
    logic [1:0]        d_valid, d_ready, d_denied;
    logic [1:0][2:0]   d_opc, d_size;
    logic [1:0][6:0]   d_src;
    logic [1:0][127:0] d_data;
    logic              dv_a_valid, dv_a_ready;
    logic [2:0]        dv_a_opc, dv_a_size;
    logic [7:0]        dv_a_src;
    logic [26:0]       dv_a_addr;
    logic [15:0]       dv_a_mask;
    logic [127:0]      dv_a_data;
    logic              dv_d_valid, dv_d_ready, dv_d_denied;
    logic [2:0]        dv_d_opc, dv_d_size;
    logic [7:0]        dv_d_src;
    logic [127:0]      dv_d_data;

    int n_vec = 0;
    int n_err = 0;

    tl_ddr_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .host_a_valid_i(a_valid), .host_a_ready_o(a_ready), .host_a_opcode_i(a_opc),
        .host_a_size_i(a_size), .host_a_source_i(a_src), .host_a_address_i(a_addr),
        .host_a_mask_i(a_mask), .host_a_data_i(a_data),
        .host_d_valid_o(d_valid), .host_d_ready_i(d_ready), .host_d_opcode_o(d_opc),
        .host_d_size_o(d_size), .host_d_source_o(d_src), .host_d_denied_o(d_denied),
        .host_d_data_o(d_data),
        .dev_a_valid_o(dv_a_valid), .dev_a_ready_i(dv_a_ready), .dev_a_opcode_o(dv_a_opc),
        .dev_a_size_o(dv_a_size), .dev_a_source_o(dv_a_src), .dev_a_address_o(dv_a_addr),
        .dev_a_mask_o(dv_a_mask), .dev_a_data_o(dv_a_data),
        .dev_d_valid_i(dv_d_valid), .dev_d_ready_o(dv_d_ready), .dev_d_opcode_i(dv_d_opc),
        .dev_d_size_i(dv_d_size), .dev_d_source_i(dv_d_src), .dev_d_denied_i(dv_d_denied),
        .dev_d_data_i(dv_d_data)
    );

    always #5 clk = ~clk;

    function automatic int exp_beats(input logic [2:0] opc, input logic [2:0] size);
        return ((opc == 3'd0 || opc == 3'd1) && int'(size) > 4) ? (1 << (int'(size) - 4)) : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = '0; a_opc = '0; a_size = '0; a_src = '0; a_addr = '0; a_mask = '0; a_data = '0;
        d_ready = '0; dv_a_ready = 1'b0; dv_d_valid = 1'b0; dv_d_opc = '0; dv_d_size = '0;
        dv_d_src = '0; dv_d_denied = 1'b0; dv_d_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int h, input logic [2:0] opc, input logic [2:0] size,
                           input logic [6:0] src, input logic [26:0] addr);
        a_valid[h] = 1'b1; a_opc[h] = opc; a_size[h] = size; a_src[h] = src; a_addr[h] = addr;
        a_mask[h] = 16'hffff; a_data[h] = {4{$urandom}};
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        a_valid = 2'b11; dv_a_ready = 1'b1; dv_d_valid = 1'b1; dv_d_src = 8'h80; d_ready = 2'b10;
        step();
        n_vec++; if (dv_a_valid !== 1'b0) begin n_err++; $display("FAIL reset_dev_a_valid got %b exp 0", dv_a_valid); end
        n_vec++; if (a_ready !== 2'b00) begin n_err++; $display("FAIL reset_host_a_ready got %b exp 00", a_ready); end
        n_vec++; if (d_valid !== 2'b00) begin n_err++; $display("FAIL reset_host_d_valid got %b exp 00", d_valid); end
        n_vec++; if (dv_d_ready !== 1'b1) begin n_err++; $display("FAIL reset_dev_d_ready got %b exp 1", dv_d_ready); end
        n_vec++; if (dut.r_ptr !== 1'b0 || dut.r_cnt !== 8'd0 || dut.r_state !== IDLE) begin
            n_err++; $display("FAIL reset_regs got ptr=%0d cnt=%0d st=%0d exp 0/0/IDLE", dut.r_ptr, dut.r_cnt, dut.r_state);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_get();
        do_reset();
        set_req(0, 3'd4, 3'd4, 7'h05, 27'h100);
        dv_a_ready = 1'b1;
        #1;
        n_vec++; if (dv_a_valid !== 1'b1) begin n_err++; $display("FAIL get_valid got %b exp 1", dv_a_valid); end
        n_vec++; if (dv_a_src !== 8'h05) begin n_err++; $display("FAIL get_source got %h exp 05", dv_a_src); end
        n_vec++; if (dv_a_addr !== 27'h100) begin n_err++; $display("FAIL get_addr got %h exp 100", dv_a_addr); end
        n_vec++; if (a_ready !== 2'b01) begin n_err++; $display("FAIL get_ready got %b exp 01", a_ready); end
        step();
        a_valid = '0; dv_a_ready = 1'b0;
        dv_d_valid = 1'b1; dv_d_src = 8'h05; d_ready = 2'b01; dv_d_data = {4{32'hcafe0001}};
        #1;
        n_vec++; if (d_valid !== 2'b01) begin n_err++; $display("FAIL get_d_valid got %b exp 01", d_valid); end
        n_vec++; if (d_src[0] !== 7'h05) begin n_err++; $display("FAIL get_d_source got %h exp 05", d_src[0]); end
        n_vec++; if (dv_d_ready !== 1'b1) begin n_err++; $display("FAIL get_d_ready got %b exp 1", dv_d_ready); end
        n_vec++; if (d_data[1] !== {4{32'hcafe0001}}) begin n_err++; $display("FAIL get_d_data got %h", d_data[1]); end
        step();
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 3'd4, 3'd4, 7'h11, 27'h200);
        set_req(1, 3'd4, 3'd4, 7'h22, 27'h300);
        dv_a_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++; if (dv_a_src[7] !== 1'(c % 2)) begin n_err++; $display("FAIL simul_grant c=%0d got %b exp %0d", c, dv_a_src[7], c % 2); end
            n_vec++; if (a_ready !== 2'(1 << (c % 2))) begin n_err++; $display("FAIL simul_ready c=%0d got %b exp %0d", c, a_ready, 1 << (c % 2)); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_burst_lock();
        do_reset();
        set_req(1, 3'd0, 3'd6, 7'h33, 27'h400);
        dv_a_ready = 1'b1;
        #1;
        n_vec++; if (dv_a_src !== 8'hb3) begin n_err++; $display("FAIL burst_first got %h exp b3", dv_a_src); end
        step();
        n_vec++; if (dut.r_cnt !== 8'd3 || dut.r_state !== BURST) begin n_err++; $display("FAIL burst_cnt1 got %0d exp 3", dut.r_cnt); end
        set_req(0, 3'd4, 3'd4, 7'h01, 27'h500);
        for (int b = 2; b <= 4; b++) begin
            #1;
            n_vec++; if (dv_a_src[7] !== 1'b1 || a_ready !== 2'b10) begin
                n_err++; $display("FAIL burst_lock beat=%0d got msb=%b rdy=%b exp 1/10", b, dv_a_src[7], a_ready);
            end
            step();
            n_vec++; if (dut.r_cnt !== 8'(4 - b)) begin n_err++; $display("FAIL burst_cnt beat=%0d got %0d exp %0d", b, dut.r_cnt, 4 - b); end
        end
        a_valid[1] = 1'b0;
        #1;
        n_vec++; if (dv_a_src !== 8'h01 || a_ready !== 2'b01) begin n_err++; $display("FAIL burst_after got %h/%b exp 01/01", dv_a_src, a_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_hold();
        logic [127:0] d0;
        do_reset();
        set_req(0, 3'd1, 3'd4, 7'h44, 27'h600);
        d0 = a_data[0];
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_req(1, 3'd4, 3'd4, 7'h55, 27'h700);
            #1;
            n_vec++; if (dv_a_src !== 8'h44 || dv_a_addr !== 27'h600 || dv_a_data !== d0 || a_ready !== 2'b00) begin
                n_err++; $display("FAIL hold_stable c=%0d got %h/%h/%b exp 44/600/00", c, dv_a_src, dv_a_addr, a_ready);
            end
            step();
            n_vec++; if (dut.r_state !== HOLD) begin n_err++; $display("FAIL hold_state c=%0d got %0d exp HOLD", c, dut.r_state); end
        end
        dv_a_ready = 1'b1;
        #1;
        n_vec++; if (dv_a_src !== 8'h44 || a_ready !== 2'b01) begin n_err++; $display("FAIL hold_fire got %h/%b exp 44/01", dv_a_src, a_ready); end
        step();
        a_valid[0] = 1'b0;
        #1;
        n_vec++; if (dv_a_src !== 8'hd5 || a_ready !== 2'b10) begin n_err++; $display("FAIL hold_next got %h/%b exp d5/10", dv_a_src, a_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_d_routing();
        idle_inputs();
        dv_d_valid = 1'b1; dv_d_src = 8'h83; d_ready = 2'b01;
        #1;
        n_vec++; if (d_valid !== 2'b10) begin n_err++; $display("FAIL droute_valid got %b exp 10", d_valid); end
        n_vec++; if (d_src[1] !== 7'h03) begin n_err++; $display("FAIL droute_source got %h exp 03", d_src[1]); end
        n_vec++; if (dv_d_ready !== 1'b0) begin n_err++; $display("FAIL droute_ready got %b exp 0", dv_d_ready); end
        d_ready = 2'b10;
        #1;
        n_vec++; if (dv_d_ready !== 1'b1) begin n_err++; $display("FAIL droute_ready1 got %b exp 1", dv_d_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(0, 3'd0, 3'd6, 7'h66, 27'h800);
        dv_a_ready = 1'b1;
        step();
        dv_d_valid = 1'b1; dv_d_src = 8'h00; d_ready = 2'b11;
        rst = 1'b1;
        #1;
        n_vec++; if (dv_a_valid !== 1'b0 || a_ready !== 2'b00 || d_valid !== 2'b00) begin
            n_err++; $display("FAIL rstmid_outputs got %b/%b/%b exp 0/00/00", dv_a_valid, a_ready, d_valid);
        end
        n_vec++; if (dut.r_cnt !== 8'd0 || dut.r_ptr !== 1'b0 || dut.r_state !== IDLE) begin
            n_err++; $display("FAIL rstmid_regs got cnt=%0d ptr=%0d st=%0d exp 0/0/IDLE", dut.r_cnt, dut.r_ptr, dut.r_state);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        set_req(1, 3'd4, 3'd4, 7'h77, 27'h900);
        dv_a_ready = 1'b1;
        #1;
        n_vec++; if (dv_a_src !== 8'hf7 || a_ready !== 2'b10) begin n_err++; $display("FAIL rstmid_fresh got %h/%b exp f7/10", dv_a_src, a_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        int ptr, lock, left, g, b;
        int hleft[2];
        bit ev, fire, rdy;
        logic [2:0] opcs[3];
        opcs[0] = 3'd0; opcs[1] = 3'd1; opcs[2] = 3'd4;
        do_reset();
        ptr = 0; lock = -1; left = 0;
        hleft[0] = 0; hleft[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int h = 0; h < 2; h++)
                if (!a_valid[h] && $urandom_range(2) == 0) begin
                    set_req(h, opcs[$urandom_range(2)], 3'($urandom_range(6)), 7'($urandom), 27'($urandom));
                    hleft[h] = exp_beats(a_opc[h], a_size[h]);
                end
            rdy = 1'($urandom_range(3) != 0);
            dv_a_ready = rdy;
            dv_d_valid = 1'($urandom); dv_d_src = 8'($urandom); d_ready = 2'($urandom);
            #1;
            ev = 1'b0; g = 0;
            if (lock >= 0) begin
                g = lock; ev = a_valid[g];
            end else begin
                for (int k = 0; k < 2; k++)
                    if (!ev && a_valid[(ptr + k) % 2]) begin ev = 1'b1; g = (ptr + k) % 2; end
            end
            fire = ev && rdy;
            n_vec++; if (dv_a_valid !== ev) begin n_err++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, dv_a_valid, ev); end
            if (ev) begin
                n_vec++; if (dv_a_src !== {1'(g), a_src[g]} || dv_a_addr !== a_addr[g] || dv_a_data !== a_data[g]) begin
                    n_err++; $display("FAIL rnd_payload c=%0d got %h/%h exp host %0d", c, dv_a_src, dv_a_addr, g);
                end
                n_vec++; if (a_ready !== (rdy ? 2'(1 << g) : 2'b00)) begin
                    n_err++; $display("FAIL rnd_ready c=%0d got %b exp host %0d rdy %b", c, a_ready, g, rdy);
                end
            end
            n_vec++; if (d_valid !== (dv_d_valid ? 2'(1 << dv_d_src[7]) : 2'b00) || dv_d_ready !== d_ready[dv_d_src[7]]
                         || d_src[dv_d_src[7]] !== dv_d_src[6:0]) begin
                n_err++; $display("FAIL rnd_d c=%0d got %b/%b exp src %h rdy %b", c, d_valid, dv_d_ready, dv_d_src, d_ready);
            end
            step();
            if (fire) begin
                if (lock >= 0 && left > 0) begin
                    left--;
                    if (left == 0) lock = -1;
                end else begin
                    ptr = (g + 1) % 2;
                    b = exp_beats(a_opc[g], a_size[g]);
                    lock = (b > 1) ? g : -1;
                    left = b - 1;
                end
                hleft[g]--;
                if (hleft[g] == 0) a_valid[g] = 1'b0;
                else a_data[g] = {4{$urandom}};
            end else if (ev && lock < 0) begin
                lock = g; left = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_get();
        test_simultaneous();
        test_burst_lock();
        test_hold();
        test_d_routing();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
